imem_loader: RTL
================

Name: imem_loader

Overview:
- Write side of the instruction memory that the reduced RISC-V core fetches from.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into DATA_WIDTH-bit words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the core in reset (cpu_rst) until the programmed number of words has been written, then releases it.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- ADDR_WIDTH, 8, instruction memory word-address width; depth is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE and DONE.
- len  input  ADDR_WIDTH+1  number of words to load; sampled on an accepted start.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte_data this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  DATA_WIDTH  word to write.
- cpu_rst  output  1  active-high reset to the core; 1 while loading.
- busy  output  1  load in progress.
- done  output  1  load finished and core released.
- csum_err  output  1  checksum mismatch (see Optional Feature).

Behaviour:
- Reset (rst=0, takes effect asynchronously):
  - state=IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst=1, busy=0, done=0, csum_err=0.
  - Byte and word counters cleared.
  - A reset mid-load aborts the load; words already written stay in memory.
- Handshake: a byte transfers on a rising edge where byte_valid=1 and byte_ready=1. byte_ready does not depend combinationally on byte_valid.
- FSM states are IDLE, RECV, WRITE, CHK and DONE.
- IDLE:
  - cpu_rst=1; byte_ready=0.
  - start with len!=0: capture len, clamping it to 2^ADDR_WIDTH if larger. Clear counters and go to RECV.
  - start with len==0: go to DONE.
- RECV:
  - byte_ready=1; busy=1.
  - Byte k of the word (k=0..DATA_WIDTH/8-1) is stored at bits [8k+7:8k].
  - When the last byte of the word is accepted, go to WRITE.
  - byte_valid low simply stalls the loader; there is no timeout.
- WRITE:
  - Lasts exactly one cycle with mem_we=1, mem_addr=word count, mem_wdata=assembled word, byte_ready=0.
  - Word count then increments.
  - If the word just written was number len-1, go to CHK (macro defined) or DONE; otherwise return to RECV.
- DONE:
  - cpu_rst=0, done=1, busy=0, byte_ready=0.
  - A new start re-enters the load path exactly as from IDLE: cpu_rst=1 and done=0 on the next cycle.
- start while busy is ignored.
- Throughput: DATA_WIDTH/8 accepted bytes plus 1 write cycle per word.
- Latency: cpu_rst falls in the cycle after the final WRITE cycle (or after CHK).
- Address wrap: cannot occur, because len is clamped; the maximum address is 2^ADDR_WIDTH-1.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of every data byte is accumulated; it is cleared on start.
  - After the last WRITE, the FSM enters CHK with byte_ready=1 and accepts one extra byte.
  - If that byte equals the XOR, go to DONE with csum_err=0.
  - Otherwise go to DONE with csum_err=1 and cpu_rst held at 1. done is still 1.
  - csum_err clears on the next start.
  - With len==0, CHK is still entered and the expected byte is 0x00.
- Undefined:
  - No CHK state and no trailing byte.
  - csum_err is tied to 0.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, then release -> cpu_rst=1, mem_we=0, byte_ready=0, done=0.
- Single-word load: start with len=1, then bytes 0x13,0x05,0x50,0x00 with valid held high -> one mem_we pulse with mem_addr=0 and mem_wdata=0x00500513; cpu_rst=0 and done=1 one cycle after the WRITE cycle.
- Back-pressure: len=2 with byte_valid toggled every other cycle -> writes 0x00000093 to address 0 and 0x00100113 to address 1; no byte lost or duplicated; exactly two mem_we pulses.
- Boundary: start with len=0 -> DONE next cycle with no mem_we. Start with len=300 and ADDR_WIDTH=8 -> exactly 256 writes, the last at mem_addr=255.
- Mid-load reset: assert rst=0 after 2 of 4 bytes -> immediate IDLE with cpu_rst=1. A later start with len=1 loads cleanly at address 0.
- IMEM_LOADER_CHECKSUM_EN defined:
  - len=1 with bytes 0x13,0x05,0x50,0x00 and trailer 0x46 -> done=1, csum_err=0, cpu_rst=0.
  - Same load with trailer 0x47 -> csum_err=1, cpu_rst=1.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Write side of the instruction memory. Packs a valid/ready byte
//            stream little-endian into DATA_WIDTH-bit words, writes them to
//            consecutive word addresses from 0, and holds the core in reset
//            (cpu_rst) until the requested number of words has been written.
// Options  : define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
//            checksum byte after the last word.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  csum_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [BCW-1:0]        BYTE_ONE  = BCW'(1);
    localparam logic [ADDR_WIDTH-1:0] WORD_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    // Largest legal load is the full memory depth.
    localparam logic [ADDR_WIDTH:0]   MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd4;
`endif

    logic [2:0]            state_q,     state_d;
    logic [ADDR_WIDTH:0]   len_q,       len_d;
    logic [BCW-1:0]        byte_cnt_q,  byte_cnt_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q,  word_cnt_d;
    logic [DATA_WIDTH-1:0] word_q,      word_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q,      csum_d;
    logic                  csum_err_q,  csum_err_d;
`endif

    // Next-state, byte assembly and write-port capture.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        csum_err_d  = csum_err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = 8'h00;
                    csum_err_d = 1'b0;
`endif
                    if (len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        len_d   = (len > MAX_LEN) ? MAX_LEN : len;
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (byte_valid) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Latch the finished word so the write port only
                        // changes when a write is actually issued.
                        byte_cnt_d  = '0;
                        mem_addr_d  = word_cnt_q;
                        mem_wdata_d = word_d;
                        state_d     = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_ONE;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + WORD_ONE;
                if ({1'b0, word_cnt_q} == (len_q - LEN_ONE)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (byte_valid) begin
                    csum_err_d = (byte_data != csum_q);
                    state_d    = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any load in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'h00;
            csum_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            csum_err_q  <= csum_err_d;
`endif
        end
    end

    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = (state_q == S_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == S_RECV) || (state_q == S_CHK);
    assign busy       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHK);
    assign csum_err   = csum_err_q;
    // A bad checksum keeps the core parked in reset even though loading ended.
    assign cpu_rst    = !((state_q == S_DONE) && !csum_err_q);
`else
    assign byte_ready = (state_q == S_RECV);
    assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
    assign csum_err   = 1'b0;
    assign cpu_rst    = (state_q != S_DONE);
`endif

endmodule
`default_nettype wire
